// File: rtl/alu_result_receiver.sv
// alu_result_receiver: 2-entry valid/ready FIFO for ALU results with flag decode and SLT checks
module alu_result_receiver #(
    parameter int         DEPTH  = 2,
    parameter logic [2:0] SLT_OP = 3'b100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic [2:0]  in_ALUop,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_is_slt,
    output logic        out_slt,
    output logic        out_zero,
    output logic        out_negative,
    output logic        err_malformed,
    output logic [15:0] slt_count
);
    logic [31:0] res_q [2];
    logic [1:0]  slt_q;
    logic        wr_q, wr_d, rd_q, rd_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [15:0] sltc_q, sltc_d;
    logic        push, pop, in_slt;

    assign in_ready      = cnt_q != 2'(DEPTH);
    assign out_valid     = cnt_q != 2'd0;
    assign push          = in_valid && in_ready;
    assign pop           = out_valid && out_ready;
    assign in_slt        = in_ALUop == SLT_OP;
    assign out_result    = res_q[rd_q];
    assign out_is_slt    = slt_q[rd_q];
    assign out_slt       = out_is_slt & out_result[0];
    assign out_zero      = out_result == 32'd0;
    assign out_negative  = out_result[31] & ~out_is_slt;
    assign err_malformed = err_q;
    assign slt_count     = sltc_q;

    // Next state for pointers, occupancy and SLT status
    always_comb begin
        wr_d   = wr_q ^ push;
        rd_d   = rd_q ^ pop;
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
        err_d  = err_q | (push & in_slt & (|in_result[31:1]));
        sltc_d = (push && in_slt && sltc_q != 16'hFFFF) ? sltc_q + 16'd1 : sltc_q;
    end

    // Control state, cleared asynchronously so reset discards buffered entries at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            cnt_q  <= 2'd0;
            err_q  <= 1'b0;
            sltc_q <= 16'd0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            sltc_q <= sltc_d;
        end
    end

    // Entry storage; contents only matter once counted as occupied
    always_ff @(posedge clk) begin
        if (push) begin
            res_q[wr_q] <= in_result;
            slt_q[wr_q] <= in_slt;
        end
    end

    // A stalled producer must hold its request and data until accepted
    assert property (@(posedge clk) disable iff (!reset_n)
        in_valid && !in_ready |=> in_valid && $stable(in_result) && $stable(in_ALUop));
endmodule

// File: tb/tb_alu_result_receiver.sv
// tb_alu_result_receiver: scoreboard bench for the ALU result receiver FIFO
module tb_alu_result_receiver;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_result = 32'd0;
    logic [2:0]  in_ALUop = 3'd0;
    logic        in_ready, out_valid, out_is_slt, out_slt, out_zero, out_negative, err_malformed;
    logic [31:0] out_result;
    logic [15:0] slt_count;

    typedef struct packed {
        logic [31:0] r;
        logic        s;
    } item_t;

    item_t       q[$];
    item_t       hd;
    int          total = 0;
    int          bad = 0;
    int          w;
    logic        exp_err = 1'b0;
    logic [15:0] exp_slt = 16'd0;

    alu_result_receiver dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_ALUop(in_ALUop),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_is_slt(out_is_slt), .out_slt(out_slt), .out_zero(out_zero), .out_negative(out_negative),
        .err_malformed(err_malformed), .slt_count(slt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] r, input logic [2:0] op, output int waited);
        bit done = 0;
        in_result = r;
        in_ALUop  = op;
        in_valid  = 1'b1;
        waited    = 0;
        while (!done && waited < 50) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back({r, op == 3'b100});
                if (op == 3'b100) begin
                    if (r[31:1] != 31'd0) exp_err = 1'b1;
                    if (exp_slt != 16'hFFFF) exp_slt++;
                end
                done = 1;
            end else waited++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!done) chk("send_timeout", {31'd0, in_ready}, 32'd1);
        chk("err_malformed", {31'd0, err_malformed}, {31'd0, exp_err});
        chk("slt_count", {16'd0, slt_count}, {16'd0, exp_slt});
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_queue", q.size(), 32'd0);
    endtask

    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        q.delete();
        exp_err = 1'b0;
        exp_slt = 16'd0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_err", {31'd0, err_malformed}, 32'd0);
        chk("rst_slt_count", {16'd0, slt_count}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Monitor: compare the head entry every cycle it is presented, retire it on a pop
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (q.size() == 0) chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            else begin
                hd = q[0];
                chk("out_result", out_result, hd.r);
                chk("out_is_slt", {31'd0, out_is_slt}, {31'd0, hd.s});
                chk("out_slt", {31'd0, out_slt}, {31'd0, hd.s & hd.r[0]});
                chk("out_zero", {31'd0, out_zero}, {31'd0, hd.r == 32'd0});
                chk("out_negative", {31'd0, out_negative}, {31'd0, hd.r[31] & ~hd.s});
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        async_reset();
        @(posedge clk);
        #1;
        send(32'h1, 3'b100, w);
        @(negedge clk);
        chk("slt_latency_out_valid", {31'd0, out_valid}, 32'd1);
        chk("slt_out_slt", {31'd0, out_slt}, 32'd1);
        @(posedge clk);
        #1;
        drain();
        send(32'h80000000, 3'b010, w);
        send(32'h0, 3'b110, w);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_negative", {31'd0, out_negative}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("no_passthrough", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("after_pop_in_ready", {31'd0, in_ready}, 32'd1);
        chk("after_pop_zero", {31'd0, out_zero}, 32'd1);
        drain();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(32'h11111111 * i + 32'(i[0] ? 32'h80000000 : 0), 3'(i), w);
            chk("stream_no_stall", w, 32'd0);
        end
        drain();
        send(32'h00000003, 3'b100, w);
        chk("malformed_result", out_result, 32'h3);
        chk("malformed_slt", {31'd0, out_slt}, 32'd1);
        out_ready = 1'b1;
        send(32'h1, 3'b100, w);
        send(32'hFFFFFFFF, 3'b001, w);
        send(32'h0, 3'b100, w);
        chk("err_sticky", {31'd0, err_malformed}, 32'd1);
        drain();
        send(32'h0000AAAA, 3'b011, w);
        send(32'h0000BBBB, 3'b100, w);
        chk("two_buffered", {31'd0, in_ready}, 32'd0);
        async_reset();
        @(posedge clk);
        #1;
        send(32'h12345678, 3'b001, w);
        @(negedge clk);
        chk("post_reset_valid", {31'd0, out_valid}, 32'd1);
        chk("post_reset_head", out_result, 32'h12345678);
        @(posedge clk);
        #1;
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_result_receiver.md
# alu_result_receiver

Receiving end of the ALU result path. Accepts the 32-bit result word and its 3-bit ALUop from the ALU result multiplexer over a valid/ready handshake and buffers it in a 2-entry FIFO. On the output side it unpacks the word into result plus decoded condition flags (zero, negative, set-less-than bit) for writeback and branch logic. It also checks that SLT results carry the zero-extended encoding.

## Interface
Parameters:
- DEPTH, 2, FIFO entries; fixed at 2, other values unsupported
- SLT_OP, 3'b100, ALUop encoding that marks a set-less-than result

Ports:
- clk  input  1  sole clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  producer has a result this cycle
- in_ready  output  1  receiver can accept (FIFO not full)
- in_result  input  32  ALU result word
- in_ALUop  input  3  ALU operation that produced in_result
- out_valid  output  1  head entry available
- out_ready  input  1  consumer takes head entry this cycle
- out_result  output  32  head result word
- out_is_slt  output  1  head entry came from SLT_OP
- out_slt  output  1  head in_result[0] when out_is_slt, else 0
- out_zero  output  1  head result == 0
- out_negative  output  1  head result[31]; forced 0 when out_is_slt
- err_malformed  output  1  sticky: an SLT entry with nonzero bits [31:1] was accepted
- slt_count  output  16  number of SLT entries accepted since reset

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- Storage: 2 entries of {result[31:0], is_slt}, read/write pointers of 1 bit each, and an occupancy count of 0..2.
- in_ready = (count != 2). No pass-through when full: a simultaneous pop does not raise in_ready in the same cycle.
- out_valid = (count != 0). All out_* data/flag outputs decode combinationally from the head entry and are don't-care when out_valid = 0.
- Push and pop in the same cycle with count = 1: count stays 1, both pointers advance, and the new entry becomes head on the next cycle.
- Push and pop in the same cycle with count = 0 is impossible, because out_valid = 0 blocks the pop.
- Pointers wrap 1 -> 0.
- is_slt = (in_ALUop == SLT_OP), captured at push.
- On a push with is_slt and in_result[31:1] != 0, err_malformed is set on that edge. It stays set until reset. The entry is still stored unchanged.
- slt_count increments by 1 on each SLT push and saturates at 16'hFFFF without wrapping.
- Producer rule (verified by assertion, not corrected): once in_valid is high, in_valid and data hold until accepted.

## Timing
- Reset (reset_n low, asynchronous) clears count, pointers, err_malformed and slt_count to 0. Outputs immediately go to in_ready = 1, out_valid = 0, err_malformed = 0, slt_count = 0.
- Reset mid-transfer discards all buffered entries; no partial pop.
- Latency: an entry pushed at edge N is visible on out_* after edge N, so out_valid rises in the cycle following acceptance.
- Throughput: 1 entry/cycle sustained when out_ready is held high.
- in_ready falls the cycle after the second unpopped push and rises the cycle after a pop from full.
- err_malformed and slt_count update on the same edge as the push.

## Test plan
- Reset then idle: reset_n = 0 mid-cycle -> in_ready = 1, out_valid = 0, slt_count = 0 immediately, without waiting for a clock edge.
- Single SLT push: in_result = 32'h1, in_ALUop = 3'b100, out_ready = 0 -> next cycle out_valid = 1, out_is_slt = 1, out_slt = 1, out_zero = 0, out_negative = 0, slt_count = 1.
- Fill and stall: push 32'h80000000 (ALUop 3'b010), then 32'h0 (ALUop 3'b110), with out_ready = 0 -> in_ready = 0 after the 2nd push. Head shows out_negative = 1. After one pop, head shows out_zero = 1, and in_ready returns to 1 the following cycle.
- Streaming: 8 back-to-back pushes with out_ready = 1 -> outputs appear in order, one per cycle, count never exceeds 1, and no stall.
- Malformed SLT: push in_result = 32'h00000003, ALUop 3'b100 -> err_malformed = 1 after that edge and stays 1 across later valid pushes. out_slt = 1 and out_result = 32'h3.
- Reset with 2 entries buffered: assert reset_n = 0 -> out_valid = 0, err_malformed = 0 and slt_count = 0 immediately. First post-reset push appears as head, with no stale data.
